// File: rtl/dkong_pkg.sv
// Shared definitions for the multi-channel DMA engine: FSM state encoding and channel limits.
package dkong_pkg;

  localparam int unsigned NCH_MAX = 4;
  localparam int unsigned CH_W    = 2;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRd,
    StWr,
    StRel
  } dma_state_e;

endpackage

// File: rtl/dkong_dma_arb.sv
// Per-channel trigger edge detection, sticky pending bits and fixed lowest-index-first priority.
module dkong_dma_arb
  import dkong_pkg::*;
#(
  parameter int unsigned NCH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NCH-1:0]  trig_i,
  input  logic            clr_i,
  input  logic [CH_W-1:0] clr_ch_i,
  output logic            any_pend_o,
  output logic [CH_W-1:0] grant_ch_o
);

  logic [NCH-1:0] trig_q;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] clr_mask;

  // A new edge always wins over the clear, so a retrigger during the
  // latch cycle still queues exactly one re-run.
  always_comb begin
    clr_mask = '0;
    for (int n = 0; n < int'(NCH); n++) begin
      clr_mask[n] = clr_i && (clr_ch_i == CH_W'(n));
    end
    pend_d = (pend_q & ~clr_mask) | (trig_i & ~trig_q);
  end

  always_comb begin
    grant_ch_o = '0;
    for (int n = int'(NCH) - 1; n >= 0; n--) begin
      if (pend_q[n]) grant_ch_o = CH_W'(n);
    end
    any_pend_o = |pend_q;
  end

  // Loading the live trigger during reset keeps a level held across release from looking like an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_q <= trig_i;
      pend_q <= '0;
    end else begin
      trig_q <= trig_i;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/dkong_dma_nch.sv
// Multi-channel bus-hold DMA engine: copies or fills LEN bytes per triggered channel, 2 ticks per byte.
module dkong_dma_nch
  import dkong_pkg::*;
#(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 10,
  parameter int unsigned DW  = 8,
  parameter int unsigned LW  = 10
) (
  input  logic              I_CLK,
  input  logic              I_RESET,
  input  logic              I_CLK_EN,
  input  logic [NCH-1:0]    I_DMA_TRIG,
  input  logic [NCH*AW-1:0] I_SRC_BASE,
  input  logic [NCH*AW-1:0] I_DST_BASE,
  input  logic [NCH*LW-1:0] I_LEN,
  input  logic [NCH-1:0]    I_FILL_MODE,
  input  logic [DW-1:0]     I_FILL_DATA,
  input  logic              I_HLDA,
  input  logic [DW-1:0]     I_DMA_DS,
  output logic              O_HRQ,
  output logic [AW-1:0]     O_DMA_AS,
  output logic              O_DMA_CES,
  output logic [AW-1:0]     O_DMA_AD,
  output logic [DW-1:0]     O_DMA_DD,
  output logic              O_DMA_CED,
  output logic              O_BUSY,
  output logic [1:0]        O_ACT_CH,
  output logic [NCH-1:0]    O_DONE
);

  dma_state_e      state_q, state_d;
  logic [CH_W-1:0] act_q, act_d;
  logic [AW-1:0]   src_q, src_d, dst_q, dst_d;
  logic [LW-1:0]   len_q, len_d, idx_q, idx_d;
  logic            fill_q, fill_d;

  logic            any_pend, latch, go;
  logic [CH_W-1:0] grant;
  logic [AW-1:0]   sel_src, sel_dst;
  logic [LW-1:0]   sel_len;
  logic            sel_fill;

  dkong_dma_arb #(
    .NCH (NCH)
  ) u_arb (
    .clk_i      (I_CLK),
    .rst_i      (I_RESET),
    .trig_i     (I_DMA_TRIG),
    .clr_i      (latch),
    .clr_ch_i   (grant),
    .any_pend_o (any_pend),
    .grant_ch_o (grant)
  );

  // Byte progress needs both a tick and the bus; losing HLDA freezes in place.
  assign go = I_CLK_EN && I_HLDA;

  always_comb begin
    sel_src  = '0;
    sel_dst  = '0;
    sel_len  = '0;
    sel_fill = 1'b0;
    for (int n = 0; n < int'(NCH); n++) begin
      if (grant == CH_W'(n)) begin
        sel_src  = I_SRC_BASE[n*AW +: AW];
        sel_dst  = I_DST_BASE[n*AW +: AW];
        sel_len  = I_LEN[n*LW +: LW];
        sel_fill = I_FILL_MODE[n];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    idx_d   = idx_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (I_CLK_EN && any_pend) begin
          latch   = 1'b1;
          act_d   = grant;
          src_d   = sel_src;
          dst_d   = sel_dst;
          len_d   = sel_len;
          fill_d  = sel_fill;
          idx_d   = '0;
          state_d = (sel_len == '0) ? StRel : StReq;
        end
      end
      StReq: if (go) state_d = StRd;
      StRd:  if (go) state_d = StWr;
      StWr: begin
        if (go) begin
          if (idx_q == len_q - LW'(1)) begin
            idx_d   = '0;
            state_d = StRel;
          end else begin
            idx_d   = idx_q + LW'(1);
            state_d = StRd;
          end
        end
      end
      StRel:   if (I_CLK_EN) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= StIdle;
      act_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      idx_q   <= idx_d;
    end
  end

  // Strobes and DONE are qualified by the advancing tick so each lasts one I_CLK;
  // everything is forced low while reset is held.
  always_comb begin
    O_HRQ     = 1'b0;
    O_DMA_AS  = '0;
    O_DMA_CES = 1'b0;
    O_DMA_AD  = '0;
    O_DMA_DD  = '0;
    O_DMA_CED = 1'b0;
    O_BUSY    = 1'b0;
    O_ACT_CH  = '0;
    O_DONE    = '0;
    if (!I_RESET) begin
      O_BUSY = (state_q != StIdle);
      O_HRQ  = (state_q == StReq) || (state_q == StRd) || (state_q == StWr);
      if (O_BUSY) O_ACT_CH = act_q;
      if (state_q == StRd && !fill_q) begin
        O_DMA_AS  = src_q + AW'(idx_q);
        O_DMA_CES = go;
      end
      if (state_q == StWr) begin
        O_DMA_AD  = dst_q + AW'(idx_q);
        O_DMA_DD  = fill_q ? I_FILL_DATA : I_DMA_DS;
        O_DMA_CED = go;
      end
      for (int n = 0; n < int'(NCH); n++) begin
        O_DONE[n] = (state_q == StRel) && I_CLK_EN && (act_q == CH_W'(n));
      end
    end
  end

endmodule

// File: doc/dkong_dma_nch.md
DKONG_DMA_NCH -- requirements
Module: dkong_dma_nch

Interface
REQ-001 SHALL have parameter NCH, default 2: number of channels, 1..4.
REQ-002 SHALL have parameter AW, default 10: address width, both source and destination.
REQ-003 SHALL have parameter DW, default 8: data width.
REQ-004 SHALL have parameter LW, default 10: transfer-length width.
REQ-005 SHALL have ports, one per line (name  direction  width  meaning):
- I_CLK  in  1  single system clock (24.576 MHz domain).
- I_RESET  in  1  synchronous active-high reset.
- I_CLK_EN  in  1  transfer tick; all FSM and datapath state advances only when high.
- I_DMA_TRIG  in  NCH  per-channel trigger, rising-edge sensitive.
- I_SRC_BASE  in  NCH*AW  per-channel source base address, channel n at bits [n*AW +: AW].
- I_DST_BASE  in  NCH*AW  per-channel destination base address.
- I_LEN  in  NCH*LW  per-channel byte count.
- I_FILL_MODE  in  NCH  1 = write I_FILL_DATA, no source reads.
- I_FILL_DATA  in  DW  fill constant.
- I_HLDA  in  1  bus-hold acknowledge from CPU.
- I_DMA_DS  in  DW  source RAM read data (1-clock RAM latency).
- O_HRQ  out  1  bus-hold request.
- O_DMA_AS  out  AW  source address.
- O_DMA_CES  out  1  source chip enable.
- O_DMA_AD  out  AW  destination address.
- O_DMA_DD  out  DW  destination write data.
- O_DMA_CED  out  1  destination write strobe.
- O_BUSY  out  1  FSM not IDLE.
- O_ACT_CH  out  2  active channel index.
- O_DONE  out  NCH  one-clock completion pulse per channel.

Function
REQ-006 SHALL detect trigger rising edges on every I_CLK and set a sticky per-channel pending bit; an edge on a channel already pending or active SHALL set pending again, queuing one re-run; further edges SHALL NOT queue more.
REQ-007 SHALL implement FSM states IDLE, REQ, RD, WR, REL; transitions SHALL occur only on ticks where I_CLK_EN=1.
REQ-008 IDLE -> REQ SHALL occur when any pending bit is set; the lowest-index pending channel SHALL be latched as active, with its pending bit cleared and its base addresses, length and mode sampled.
REQ-009 O_HRQ SHALL be high in REQ, RD and WR; REQ -> RD SHALL occur on the first tick with I_HLDA=1.
REQ-010 RD SHALL drive O_DMA_AS = src+i and O_DMA_CES=1; the following tick is WR.
REQ-011 WR SHALL drive O_DMA_AD = dst+i, O_DMA_DD = I_DMA_DS (fill mode: I_FILL_DATA) and O_DMA_CED=1; then i increments, returning to RD, or to REL after the last byte.
REQ-012 In fill mode, O_DMA_CES SHALL stay 0 throughout.
REQ-013 Throughput SHALL be 2 ticks per byte; total duration = 1 (REQ, if HLDA already high) + 2*LEN + 1 (REL) ticks.
REQ-014 Addresses SHALL wrap modulo 2^AW.
REQ-015 LEN=0 SHALL skip REQ/RD/WR, go IDLE -> REL directly and pulse O_DONE without raising O_HRQ.
REQ-016 If I_HLDA falls in RD or WR, the FSM SHALL hold state with O_DMA_CES and O_DMA_CED at 0 (O_HRQ stays high) and resume at the same byte when I_HLDA returns.
REQ-017 REL SHALL drop O_HRQ, pulse O_DONE[active] for exactly one I_CLK, then go to IDLE.
REQ-018 O_DMA_CES and O_DMA_CED SHALL be asserted for one I_CLK per strobe.
REQ-019 Channel selection SHALL occur only in IDLE; a higher-priority trigger during a transfer SHALL wait for that transfer to complete.

Reset
REQ-020 I_RESET SHALL act at any clock regardless of I_CLK_EN, returning to IDLE and clearing pending bits and edge history.
REQ-021 During and after reset, all outputs SHALL be 0.
REQ-022 Reset mid-transfer SHALL abort with no O_DONE pulse and drop O_HRQ the next clock.
REQ-023 A trigger held high across reset release SHALL NOT count as an edge.

Structure
REQ-024 The FSM state enum and the NCH maximum (4) SHALL live in the shared package dkong_pkg.
REQ-025 The per-channel edge-detect/pending/priority logic SHALL be one sub-module, dkong_dma_arb.

Verification
REQ-026 The bench SHALL cover these scenarios:
- NCH=2, ch0 src 0x100, dst 0x000, LEN 0x180, HLDA tied 1 -> 384 CED strobes, AD 0x000..0x17F, data matches source, O_DONE[0] after 770 ticks.
- ch0 and ch1 triggered in the same clock -> ch0 runs fully first, then ch1; O_ACT_CH 0 then 1.
- ch1 fill mode, data 0xAA, LEN 4, dst 0x3FE -> writes to 0x3FE, 0x3FF, 0x000, 0x001; CES never high.
- HLDA dropped for 5 ticks after byte 10 -> no strobes during the gap; byte 11 written at dst+11; no byte lost or duplicated.
- LEN=0 -> O_DONE pulse, O_HRQ never high.
- Reset asserted at byte 50 -> outputs 0 next clock, no O_DONE; a fresh trigger afterwards restarts at byte 0.
